// File: rtl/vram_cpu_port.sv
// CPU-side VDP port: control-port byte sequencer plus toggle-handshake
// requests to the VRAM arbiter for address set, data write and read prefetch.
module vram_cpu_port (
  input  logic        CLK21M,
  input  logic        RESET,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic        cpu_ctrl_wr,
  input  logic [7:0]  cpu_din,
  input  logic [3:0]  reg_r14,
  input  logic [7:0]  pram_dbi,
  input  logic        VDPVRAMWRACK,
  input  logic        VDPVRAMRDACK,
  input  logic        VDPVRAMADDRSETACK,
  input  logic        VDPVRAMREADINGR,
  output logic [7:0]  VDPVRAMACCESSDATA,
  output logic [17:0] VDPVRAMACCESSADDRTMP,
  output logic        VDPVRAMWRREQ,
  output logic        VDPVRAMRDREQ,
  output logic        VDPVRAMADDRSETREQ,
  output logic        VDPVRAMREADINGA,
  output logic [7:0]  cpu_dout,
  output logic        reg_wr,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic        wr_overrun
);

  typedef enum logic {ST_FIRST, ST_SECOND} state_t;

  state_t      state_q, state_d;
  logic [7:0]  first_byte_q, first_byte_d;
  logic [17:0] addr_tmp_q, addr_tmp_d;
  logic [7:0]  access_data_q, access_data_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic        addr_set_req_q, addr_set_req_d;
  logic        reading_a_q, reading_a_d;
  logic [7:0]  read_buf_q, read_buf_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        reg_wr_q, reg_wr_d;
  logic [5:0]  reg_num_q, reg_num_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        wr_overrun_q, wr_overrun_d;

  logic wr_pending, rd_pending, addr_set_pending;

  assign wr_pending       = wr_req_q != VDPVRAMWRACK;
  assign rd_pending       = rd_req_q != VDPVRAMRDACK;
  assign addr_set_pending = addr_set_req_q != VDPVRAMADDRSETACK;

  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      state_q        <= ST_FIRST;
      first_byte_q   <= 8'h00;
      addr_tmp_q     <= 18'h00000;
      access_data_q  <= 8'h00;
      wr_req_q       <= 1'b0;
      rd_req_q       <= 1'b0;
      addr_set_req_q <= 1'b0;
      reading_a_q    <= 1'b0;
      read_buf_q     <= 8'h00;
      cpu_dout_q     <= 8'h00;
      reg_wr_q       <= 1'b0;
      reg_num_q      <= 6'h00;
      reg_data_q     <= 8'h00;
      wr_overrun_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_byte_q   <= first_byte_d;
      addr_tmp_q     <= addr_tmp_d;
      access_data_q  <= access_data_d;
      wr_req_q       <= wr_req_d;
      rd_req_q       <= rd_req_d;
      addr_set_req_q <= addr_set_req_d;
      reading_a_q    <= reading_a_d;
      read_buf_q     <= read_buf_d;
      cpu_dout_q     <= cpu_dout_d;
      reg_wr_q       <= reg_wr_d;
      reg_num_q      <= reg_num_d;
      reg_data_q     <= reg_data_d;
      wr_overrun_q   <= wr_overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    first_byte_d   = first_byte_q;
    addr_tmp_d     = addr_tmp_q;
    access_data_d  = access_data_q;
    wr_req_d       = wr_req_q;
    rd_req_d       = rd_req_q;
    addr_set_req_d = addr_set_req_q;
    reading_a_d    = reading_a_q;
    read_buf_d     = read_buf_q;
    cpu_dout_d     = cpu_dout_q;
    reg_wr_d       = 1'b0;
    reg_num_d      = reg_num_q;
    reg_data_d     = reg_data_q;
    wr_overrun_d   = wr_overrun_q;

    // Only one CPU pulse is honoured per cycle: ctrl_wr > data_wr > data_rd.
    if (cpu_ctrl_wr) begin
      if (state_q == ST_FIRST) begin
        first_byte_d = cpu_din;
        state_d      = ST_SECOND;
      end else begin
        state_d = ST_FIRST;
        if (cpu_din[7]) begin
          reg_wr_d   = 1'b1;
          reg_num_d  = cpu_din[5:0];
          reg_data_d = first_byte_q;
        end else begin
          addr_tmp_d = {reg_r14, cpu_din[5:0], first_byte_q};
          if (!addr_set_pending) addr_set_req_d = ~addr_set_req_q;
          if (!cpu_din[6] && !rd_pending) rd_req_d = ~rd_req_q;
        end
      end
    end else if (cpu_data_wr) begin
      state_d = ST_FIRST;
      if (!wr_pending) begin
        access_data_d = cpu_din;
        wr_req_d      = ~wr_req_q;
      end else begin
        wr_overrun_d = 1'b1;
      end
    end else if (cpu_data_rd) begin
      state_d    = ST_FIRST;
      cpu_dout_d = read_buf_q;
      if (!rd_pending) rd_req_d = ~rd_req_q;
    end

    // Capture runs alongside any CPU access; a same-cycle read sees the old buffer.
    if (VDPVRAMREADINGR != reading_a_q) begin
      read_buf_d  = pram_dbi;
      reading_a_d = VDPVRAMREADINGR;
    end
  end

  assign VDPVRAMACCESSDATA    = access_data_q;
  assign VDPVRAMACCESSADDRTMP = addr_tmp_q;
  assign VDPVRAMWRREQ         = wr_req_q;
  assign VDPVRAMRDREQ         = rd_req_q;
  assign VDPVRAMADDRSETREQ    = addr_set_req_q;
  assign VDPVRAMREADINGA      = reading_a_q;
  assign cpu_dout             = cpu_dout_q;
  assign reg_wr               = reg_wr_q;
  assign reg_num              = reg_num_q;
  assign reg_data             = reg_data_q;
  assign wr_overrun           = wr_overrun_q;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed bench for vram_cpu_port: a small protocol model pushes expected
// outputs into a scoreboard queue each step, popped and compared after the clock edge.
module tb_vram_cpu_port;

  logic        CLK21M = 1'b0;
  logic        RESET;
  logic        cpu_data_wr, cpu_data_rd, cpu_ctrl_wr;
  logic [7:0]  cpu_din;
  logic [3:0]  reg_r14;
  logic [7:0]  pram_dbi;
  logic        VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR;
  logic [7:0]  VDPVRAMACCESSDATA;
  logic [17:0] VDPVRAMACCESSADDRTMP;
  logic        VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ, VDPVRAMREADINGA;
  logic [7:0]  cpu_dout;
  logic        reg_wr;
  logic [5:0]  reg_num;
  logic [7:0]  reg_data;
  logic        wr_overrun;

  vram_cpu_port dut (
    .CLK21M(CLK21M), .RESET(RESET),
    .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd), .cpu_ctrl_wr(cpu_ctrl_wr),
    .cpu_din(cpu_din), .reg_r14(reg_r14), .pram_dbi(pram_dbi),
    .VDPVRAMWRACK(VDPVRAMWRACK), .VDPVRAMRDACK(VDPVRAMRDACK),
    .VDPVRAMADDRSETACK(VDPVRAMADDRSETACK), .VDPVRAMREADINGR(VDPVRAMREADINGR),
    .VDPVRAMACCESSDATA(VDPVRAMACCESSDATA), .VDPVRAMACCESSADDRTMP(VDPVRAMACCESSADDRTMP),
    .VDPVRAMWRREQ(VDPVRAMWRREQ), .VDPVRAMRDREQ(VDPVRAMRDREQ),
    .VDPVRAMADDRSETREQ(VDPVRAMADDRSETREQ), .VDPVRAMREADINGA(VDPVRAMREADINGA),
    .cpu_dout(cpu_dout), .reg_wr(reg_wr), .reg_num(reg_num), .reg_data(reg_data),
    .wr_overrun(wr_overrun)
  );

  always #5 CLK21M = ~CLK21M;

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string step = "init";

  // Expected-behaviour model state.
  logic        m_second;
  logic [7:0]  m_first;
  logic [17:0] m_addr;
  logic [7:0]  m_access, m_buf, m_dout, m_reg_data;
  logic        m_wr, m_rd, m_as, m_ra, m_reg_wr, m_ovr;
  logic [5:0]  m_reg_num;

  task automatic tick();
    @(posedge CLK21M);
    #1;
  endtask

  task automatic pushExp(input string tag, input logic [17:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [17:0] obs);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s/%s scoreboard empty, observed=%h", step, tag, obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("[TB] FAIL %s/%s observed=%h expected=%h", step, e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pushModel();
    pushExp("addr",     m_addr);
    pushExp("access",   18'(m_access));
    pushExp("wrreq",    18'(m_wr));
    pushExp("rdreq",    18'(m_rd));
    pushExp("asreq",    18'(m_as));
    pushExp("readinga", 18'(m_ra));
    pushExp("dout",     18'(m_dout));
    pushExp("reg_wr",   18'(m_reg_wr));
    pushExp("reg_num",  18'(m_reg_num));
    pushExp("reg_data", 18'(m_reg_data));
    pushExp("overrun",  18'(m_ovr));
  endtask

  task automatic popAll();
    checkOutput("addr",     VDPVRAMACCESSADDRTMP);
    checkOutput("access",   18'(VDPVRAMACCESSDATA));
    checkOutput("wrreq",    18'(VDPVRAMWRREQ));
    checkOutput("rdreq",    18'(VDPVRAMRDREQ));
    checkOutput("asreq",    18'(VDPVRAMADDRSETREQ));
    checkOutput("readinga", 18'(VDPVRAMREADINGA));
    checkOutput("dout",     18'(cpu_dout));
    checkOutput("reg_wr",   18'(reg_wr));
    checkOutput("reg_num",  18'(reg_num));
    checkOutput("reg_data", 18'(reg_data));
    checkOutput("overrun",  18'(wr_overrun));
  endtask

  // kind: 0 ctrl_wr, 1 data_wr, 2 data_rd, 3 idle, 4 ctrl_wr+data_wr together
  task automatic applyStimulus(input int kind, input logic [7:0] din);
    m_reg_wr = 1'b0;
    if (kind == 0 || kind == 4) begin
      if (!m_second) begin
        m_first  = din;
        m_second = 1'b1;
      end else begin
        m_second = 1'b0;
        if (din[7]) begin
          m_reg_wr   = 1'b1;
          m_reg_num  = din[5:0];
          m_reg_data = m_first;
        end else begin
          m_addr = {reg_r14, din[5:0], m_first};
          if (m_as == VDPVRAMADDRSETACK) m_as = ~m_as;
          if (!din[6] && m_rd == VDPVRAMRDACK) m_rd = ~m_rd;
        end
      end
    end else if (kind == 1) begin
      m_second = 1'b0;
      if (m_wr == VDPVRAMWRACK) begin
        m_access = din;
        m_wr     = ~m_wr;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (kind == 2) begin
      m_second = 1'b0;
      m_dout   = m_buf;
      if (m_rd == VDPVRAMRDACK) m_rd = ~m_rd;
    end
    if (VDPVRAMREADINGR != m_ra) begin
      m_buf = pram_dbi;
      m_ra  = VDPVRAMREADINGR;
    end
    pushModel();
    cpu_din     = din;
    cpu_ctrl_wr = (kind == 0 || kind == 4);
    cpu_data_wr = (kind == 1 || kind == 4);
    cpu_data_rd = (kind == 2);
    tick();
    cpu_ctrl_wr = 1'b0;
    cpu_data_wr = 1'b0;
    cpu_data_rd = 1'b0;
    popAll();
  endtask

  task automatic doReset();
    RESET = 1'b1;
    VDPVRAMWRACK = 1'b0;
    VDPVRAMRDACK = 1'b0;
    VDPVRAMADDRSETACK = 1'b0;
    VDPVRAMREADINGR = 1'b0;
    m_second = 1'b0; m_first = 8'h00; m_addr = 18'h0; m_access = 8'h00;
    m_buf = 8'h00; m_dout = 8'h00; m_reg_data = 8'h00; m_reg_num = 6'h00;
    m_wr = 1'b0; m_rd = 1'b0; m_as = 1'b0; m_ra = 1'b0; m_reg_wr = 1'b0; m_ovr = 1'b0;
    pushModel();
    tick();
    RESET = 1'b0;
    popAll();
  endtask

  initial begin
    RESET = 1'b1;
    cpu_data_wr = 1'b0; cpu_data_rd = 1'b0; cpu_ctrl_wr = 1'b0;
    cpu_din = 8'h00; reg_r14 = 4'h0; pram_dbi = 8'h00;
    VDPVRAMWRACK = 1'b0; VDPVRAMRDACK = 1'b0;
    VDPVRAMADDRSETACK = 1'b0; VDPVRAMREADINGR = 1'b0;

    step = "reset";
    doReset();

    step = "addrset";
    reg_r14 = 4'h2;
    applyStimulus(0, 8'h34);
    applyStimulus(0, 8'h52);
    pushExp("addr_lit", 18'h09234);
    checkOutput("addr_lit", VDPVRAMACCESSADDRTMP);
    pushExp("asreq_lit", 18'h1);
    checkOutput("asreq_lit", 18'(VDPVRAMADDRSETREQ));
    pushExp("rdreq_lit", 18'h0);
    checkOutput("rdreq_lit", 18'(VDPVRAMRDREQ));
    VDPVRAMADDRSETACK = 1'b1;
    applyStimulus(3, 8'h00);

    step = "readsetup";
    reg_r14 = 4'h0;
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h10);
    pushExp("addr_lit", 18'h01000);
    checkOutput("addr_lit", VDPVRAMACCESSADDRTMP);
    VDPVRAMADDRSETACK = 1'b0;
    VDPVRAMRDACK = 1'b1;
    pram_dbi = 8'hA5;
    VDPVRAMREADINGR = 1'b1;
    applyStimulus(3, 8'h00);
    applyStimulus(2, 8'h00);
    pushExp("dout_lit", 18'h000A5);
    checkOutput("dout_lit", 18'(cpu_dout));

    step = "pendaddr";
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h01);
    applyStimulus(0, 8'h02);
    applyStimulus(0, 8'h41);
    pushExp("addr_lit", 18'h00102);
    checkOutput("addr_lit", VDPVRAMACCESSADDRTMP);
    VDPVRAMADDRSETACK = 1'b1;
    applyStimulus(3, 8'h00);

    step = "regwr";
    applyStimulus(0, 8'h1F);
    applyStimulus(0, 8'h87);
    pushExp("regwr_lit", 18'h1);
    checkOutput("regwr_lit", 18'(reg_wr));
    pushExp("regnum_lit", 18'h7);
    checkOutput("regnum_lit", 18'(reg_num));
    pushExp("regdata_lit", 18'h1F);
    checkOutput("regdata_lit", 18'(reg_data));
    applyStimulus(3, 8'h00);

    step = "overrun";
    applyStimulus(1, 8'h11);
    applyStimulus(1, 8'h22);
    pushExp("access_lit", 18'h11);
    checkOutput("access_lit", 18'(VDPVRAMACCESSDATA));
    pushExp("overrun_lit", 18'h1);
    checkOutput("overrun_lit", 18'(wr_overrun));
    VDPVRAMWRACK = 1'b1;
    applyStimulus(1, 8'h33);

    step = "capture_rd";
    VDPVRAMRDACK = 1'b0;
    pram_dbi = 8'h3C;
    VDPVRAMREADINGR = 1'b0;
    applyStimulus(2, 8'h00);
    pushExp("dout_lit", 18'h000A5);
    checkOutput("dout_lit", 18'(cpu_dout));
    applyStimulus(2, 8'h00);

    step = "priority";
    VDPVRAMWRACK = 1'b0;
    applyStimulus(4, 8'h77);
    applyStimulus(0, 8'h40);
    pushExp("addr_lit", 18'h00077);
    checkOutput("addr_lit", VDPVRAMACCESSADDRTMP);

    step = "ffreset";
    applyStimulus(0, 8'h55);
    applyStimulus(2, 8'h00);
    applyStimulus(0, 8'h66);
    applyStimulus(0, 8'h40);
    pushExp("addr14_lit", 18'h00066);
    checkOutput("addr14_lit", VDPVRAMACCESSADDRTMP & 18'h03FFF);

    step = "reset_mid";
    applyStimulus(0, 8'h99);
    doReset();
    applyStimulus(0, 8'h12);
    applyStimulus(0, 8'h40);
    pushExp("addr14_lit", 18'h00012);
    checkOutput("addr14_lit", VDPVRAMACCESSADDRTMP & 18'h03FFF);

    $display("%0d/%0d checks passed", checks - failures, checks);
    $finish;
  end

endmodule
